// File: rtl/interleaver_pkg.sv
// Shared definitions for the ping-pong 802.11a interleaver: RATE codes,
// the per-rate symbol geometry lookup and the default bank depth.
package interleaver_pkg;

  localparam int NCBPS_MAX_DEFAULT = 288;

  localparam logic [3:0] RATE_6M  = 4'b1101;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b0101;
  localparam logic [3:0] RATE_18M = 4'b0111;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1011;
  localparam logic [3:0] RATE_48M = 4'b0001;
  localparam logic [3:0] RATE_54M = 4'b0011;

  // Symbol geometry: coded bits per symbol, that value divided by 16, and s
  typedef struct packed {
    logic [8:0] n;
    logic [4:0] n16;
    logic [1:0] s;
  } rate_cfg_t;

  // Unknown codes fall back to the 6 Mbit/s geometry
  function automatic rate_cfg_t rate_to_ncbps(input logic [3:0] rate);
    rate_cfg_t cfg;
    case (rate)
      RATE_12M, RATE_18M: cfg = '{n: 9'd96,  n16: 5'd6,  s: 2'd1};
      RATE_24M, RATE_36M: cfg = '{n: 9'd192, n16: 5'd12, s: 2'd2};
      RATE_48M, RATE_54M: cfg = '{n: 9'd288, n16: 5'd18, s: 2'd3};
      RATE_6M, RATE_9M:   cfg = '{n: 9'd48,  n16: 5'd3,  s: 2'd1};
      default:            cfg = '{n: 9'd48,  n16: 5'd3,  s: 2'd1};
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/interleaver_perm.sv
// Combinational 802.11a interleaver permutation k -> P(k).
// Because i is built as (N/16)*(k mod 16) + floor(k/16) with floor(k/16) < N/16,
// floor(16*i/N) is exactly k mod 16, so no divider by N is needed. The only
// remaining division is by the constant s (1, 2 or 3).
module interleaver_perm
  import interleaver_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic [AW-1:0] k_i,
  input  logic [AW-1:0] n_i,
  input  logic [4:0]    n16_i,
  input  logic [1:0]    s_i,
  output logic [AW-1:0] p_o
);

  logic [AW-1:0] kmod;
  logic [AW-1:0] kdiv;
  logic [AW-1:0] n16;
  logic [AW-1:0] i_val;
  logic [AW:0]   t_val;
  logic [1:0]    i_rem;
  logic [1:0]    t_rem;

  // Remainder modulo s for s in {1,2,3}
  function automatic logic [1:0] mod_s(input logic [AW:0] v, input logic [1:0] s);
    logic [AW:0] r;
    case (s)
      2'd2:    r = {{AW{1'b0}}, v[0]};
      2'd3:    r = v % (AW+1)'(3);
      default: r = '0;
    endcase
    return r[1:0];
  endfunction

  // First and second permutation steps, j = i - (i mod s) + ((i + N - k mod 16) mod s)
  always_comb begin
    kmod  = {{(AW-4){1'b0}}, k_i[3:0]};
    kdiv  = k_i >> 4;
    n16   = {{(AW-5){1'b0}}, n16_i};
    i_val = n16 * kmod + kdiv;
    t_val = {1'b0, i_val} + {1'b0, n_i} - {1'b0, kmod};
    i_rem = mod_s({1'b0, i_val}, s_i);
    t_rem = mod_s(t_val, s_i);
    p_o   = i_val - {{(AW-2){1'b0}}, i_rem} + {{(AW-2){1'b0}}, t_rem};
  end

endmodule

// File: rtl/interleaver_pp.sv
// Ping-pong 802.11a bit interleaver. One bank is filled (permuted write)
// while the other is read out sequentially, so samples stream at one per clock.
// Optional deinterleave mode is compiled in with INTERLEAVER_DEINT_EN: the
// Deint input selects sequential write plus permuted read for that symbol.
module interleaver_pp
  import interleaver_pkg::*;
#(
  parameter int W         = 1,
  parameter int NCBPS_MAX = NCBPS_MAX_DEFAULT,
  parameter int AW        = 9
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [W-1:0] x,
  input  logic [3:0]   Rate,
`ifdef INTERLEAVER_DEINT_EN
  input  logic         Deint,
`endif
  output logic [W-1:0] y,
  output logic         Valid,
  output logic         Sym_First,
  output logic [8:0]   Ncbps
);

  localparam int DEPTH = 2 * NCBPS_MAX;

  rate_cfg_t       rate_cfg;
  logic [1:0][8:0] bank_n_q, bank_n_d;
  logic [1:0][4:0] bank_n16_q, bank_n16_d;
  logic [1:0][1:0] bank_s_q, bank_s_d;
  logic [1:0]      full_q, full_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
`ifdef INTERLEAVER_DEINT_EN
  logic [1:0]      bank_deint_q, bank_deint_d;
  logic            wr_deint;
  logic            rd_deint;
  logic [AW-1:0]   perm_rd;
`endif
  logic [8:0]      wr_n;
  logic [4:0]      wr_n16;
  logic [1:0]      wr_s;
  logic [8:0]      rd_n;
  logic            rd_go;
  logic [AW-1:0]   perm_wr;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    rd_data_p1;
  logic            vld_p1;
  logic            first_p1;
  logic [8:0]      ncbps_p1;

  // Flat RAM index: bank 1 sits above bank 0
  function automatic logic [AW:0] bank_index(input logic bank, input logic [AW-1:0] addr);
    return bank ? (AW+1)'(NCBPS_MAX) + {1'b0, addr} : {1'b0, addr};
  endfunction

  // Write-side geometry: live Rate on the first sample, latched value afterwards
  always_comb begin
    rate_cfg = rate_to_ncbps(Rate);
    if (wr_cnt_q == '0) begin
      wr_n   = rate_cfg.n;
      wr_n16 = rate_cfg.n16;
      wr_s   = rate_cfg.s;
    end else begin
      wr_n   = bank_n_q[wr_bank_q];
      wr_n16 = bank_n16_q[wr_bank_q];
      wr_s   = bank_s_q[wr_bank_q];
    end
  end

  assign rd_n  = bank_n_q[rd_bank_q];
  assign rd_go = full_q[rd_bank_q];

  interleaver_perm #(.AW(AW)) u_perm_wr (
    .k_i   (wr_cnt_q),
    .n_i   (AW'(wr_n)),
    .n16_i (wr_n16),
    .s_i   (wr_s),
    .p_o   (perm_wr)
  );

`ifdef INTERLEAVER_DEINT_EN
  assign wr_deint = (wr_cnt_q == '0) ? Deint : bank_deint_q[wr_bank_q];
  assign rd_deint = bank_deint_q[rd_bank_q];

  interleaver_perm #(.AW(AW)) u_perm_rd (
    .k_i   (rd_cnt_q),
    .n_i   (AW'(rd_n)),
    .n16_i (bank_n16_q[rd_bank_q]),
    .s_i   (bank_s_q[rd_bank_q]),
    .p_o   (perm_rd)
  );

  assign wr_addr = wr_deint ? wr_cnt_q : perm_wr;
  assign rd_addr = rd_deint ? perm_rd : rd_cnt_q;
`else
  assign wr_addr = perm_wr;
  assign rd_addr = rd_cnt_q;
`endif

  // Counter, bank-select and full-flag next state for both sides
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    rd_cnt_d   = rd_cnt_q;
    rd_bank_d  = rd_bank_q;
    full_d     = full_q;
    bank_n_d   = bank_n_q;
    bank_n16_d = bank_n16_q;
    bank_s_d   = bank_s_q;
`ifdef INTERLEAVER_DEINT_EN
    bank_deint_d = bank_deint_q;
`endif
    if (Start) begin
      if (wr_cnt_q == '0) begin
        bank_n_d[wr_bank_q]   = wr_n;
        bank_n16_d[wr_bank_q] = wr_n16;
        bank_s_d[wr_bank_q]   = wr_s;
`ifdef INTERLEAVER_DEINT_EN
        bank_deint_d[wr_bank_q] = wr_deint;
`endif
      end
      if (wr_cnt_q == AW'(wr_n - 9'd1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_cnt_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    if (rd_go) begin
      if (rd_cnt_q == AW'(rd_n - 9'd1)) begin
        full_d[rd_bank_q] = 1'b0;
        rd_cnt_d          = '0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  // Control state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      rd_bank_q  <= 1'b0;
      full_q     <= '0;
      bank_n_q   <= '0;
      bank_n16_q <= '0;
      bank_s_q   <= '0;
`ifdef INTERLEAVER_DEINT_EN
      bank_deint_q <= '0;
`endif
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      bank_n_q   <= bank_n_d;
      bank_n16_q <= bank_n16_d;
      bank_s_q   <= bank_s_d;
`ifdef INTERLEAVER_DEINT_EN
      bank_deint_q <= bank_deint_d;
`endif
    end
  end

  // Sample RAM write port
  always_ff @(posedge Clk) begin
    if (Start) mem_q[bank_index(wr_bank_q, wr_addr)] <= x;
  end

  // ---- stage p1: registered RAM read ----
  // RAM read data (not reset, contents are don't-care until valid)
  always_ff @(posedge Clk) begin
    rd_data_p1 <= mem_q[bank_index(rd_bank_q, rd_addr)];
  end

  // Read-side valid, first-sample flag and symbol size travelling with the data
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      ncbps_p1 <= '0;
    end else begin
      vld_p1   <= rd_go;
      first_p1 <= rd_go && (rd_cnt_q == '0);
      if (rd_go) ncbps_p1 <= rd_n;
    end
  end

  // ---- stage p2: output register ----
  // Output register; Ncbps holds the size of the most recent symbol
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      y         <= '0;
      Valid     <= 1'b0;
      Sym_First <= 1'b0;
      Ncbps     <= '0;
    end else begin
      y         <= vld_p1 ? rd_data_p1 : '0;
      Valid     <= vld_p1;
      Sym_First <= first_p1;
      if (vld_p1) Ncbps <= ncbps_p1;
    end
  end

endmodule
